dmem_responder: RTL

Data-memory responder: the memory end of the core's load/store port, as a valid/ready request/response slave.
- Accepts one byte-addressed load or store per transaction and decodes RISC-V funct3 width/sign.
- Performs byte-lane write merging and load sign/zero extension.
- Returns a response after a fixed, parameterised latency.
- Sits between the EX/MEM stage and the word-organised storage array; `busy` feeds the pipeline stall logic.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_lane_align.sv | 64 ++++++
 rtl/dmem_responder.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and latency counter width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for LATENCY up to 15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the EX/MEM stage (master) and the responder (slave).
// Request: valid/ready/we/addr/wdata/funct3. Response: valid/ready/rdata/err. Plus busy.
interface dmem_responder_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [2:0]            req_funct3;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store merge + byte enables, load extension,
// illegal-funct3 and misalignment flags. Ports: we/funct3/addr[1:0]/wdata/old in.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_i,
    output logic [31:0] wword_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o,
    output logic        illegal_o,
    output logic        misalign_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] wsrc;

    assign byte_sel = old_i[{addr_i, 3'b000} +: 8];
    assign half_sel = addr_i[1] ? old_i[31:16] : old_i[15:0];

    always_comb begin
        be_o       = 4'b0000;
        wsrc       = wdata_i;
        rdata_o    = 32'h0;
        illegal_o  = 1'b0;
        misalign_o = 1'b0;
        unique case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << addr_i;
                wsrc    = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
                wsrc       = {2{wdata_i[15:0]}};
                rdata_o    = {{16{half_sel[15]}}, half_sel};
                misalign_o = addr_i[0];
            end
            F3_W: begin
                be_o       = 4'b1111;
                rdata_o    = old_i;
                misalign_o = |addr_i;
            end
            F3_BU: begin
                illegal_o = we_i;
                rdata_o   = {24'h0, byte_sel};
            end
            F3_HU: begin
                illegal_o  = we_i;
                rdata_o    = {16'h0, half_sel};
                misalign_o = addr_i[0];
            end
            default: illegal_o = 1'b1;
        endcase
        if (!we_i || illegal_o) be_o = 4'b0000;
        wword_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (be_o[i]) wword_o[8*i +: 8] = wsrc[8*i +: 8];
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready slave with fixed LATENCY, word storage.
// Ports: clk, reset (async high), bus (slave). Macro: DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int LATENCY    = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);

    dmem_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [2:0]            f3_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic                  accept, enter_resp, err;
    logic                  cur_we;
    logic [DM_ADDRESS-1:0] cur_addr;
    logic [DATA_W-1:0]     cur_wdata, old_word, wword, ld_data;
    logic [2:0]            cur_f3;
    logic [3:0]            be;
    logic                  illegal, misalign;

    assign accept = bus.req_valid && (state_q == IDLE);

    // With LATENCY==1 the commit happens on the accept edge itself,
    // so the live request fields must feed the lane logic.
    assign cur_we    = (state_q == IDLE) ? bus.req_we     : we_q;
    assign cur_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
    assign cur_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
    assign cur_f3    = (state_q == IDLE) ? bus.req_funct3 : f3_q;
    assign old_word  = mem[cur_addr[DM_ADDRESS-1:2]];

    dmem_lane_align u_align (
        .we_i      (cur_we),
        .funct3_i  (cur_f3),
        .addr_i    (cur_addr[1:0]),
        .wdata_i   (cur_wdata),
        .old_i     (old_word),
        .wword_o   (wword),
        .be_o      (be),
        .rdata_o   (ld_data),
        .illegal_o (illegal),
        .misalign_o(misalign)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err = illegal | misalign;
`else
    assign err = illegal;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                f3_q    <= bus.req_funct3;
            end
            if (enter_resp) begin
                rdata_q <= (cur_we || err) ? '0 : ld_data;
                err_q   <= err;
            end
        end
    end

    // Storage is never reset; a reset before the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (enter_resp && !reset && !err && (|be)) begin
            mem[cur_addr[DM_ADDRESS-1:2]] <= wword;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
